// File: rtl/bram_fifo_ctrl.sv
// Single-clock FIFO controller in front of an external dual-port block RAM.
// RAM port 1 is the write port and RAM port 2 is the read port.
// The RAM registers its read data, so read data arrives one cycle after the read.
// rd_valid is registered to match that cycle.
// Occupancy is the difference of two AW+1 bit pointers.
// The extra pointer bit tells full apart from empty.
module bram_fifo_ctrl #(
    parameter int AW       = 6,
    parameter int DW       = 16,
    parameter int AF_LEVEL = 56,
    parameter int AE_LEVEL = 8
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          clr,
    input  logic          wr_req,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_req,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          full,
    output logic          empty,
    output logic          almost_full,
    output logic          almost_empty,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic          underflow,
    output logic          ram_en1,
    output logic          ram_we1,
    output logic [AW-1:0] ram_addr1,
    output logic [DW-1:0] ram_DI1,
    output logic          ram_en2,
    output logic          ram_we2,
    output logic [AW-1:0] ram_addr2,
    input  logic [DW-1:0] ram_DO2
);

    localparam logic [AW:0] DEPTH  = (AW+1)'(2**AW);
    localparam logic [AW:0] AF_LVL = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_LVL = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] ONE    = (AW+1)'(1);

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic        rd_valid_q, rd_valid_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        wr_accept;
    logic        rd_accept;

    // Flags decode only from registered pointers, so they change cleanly once per clock.
    always_comb begin
        count        = wptr_q - rptr_q;
        empty        = (count == '0);
        full         = (count == DEPTH);
        almost_full  = (count >= AF_LVL);
        almost_empty = (count <= AE_LVL);
    end

    // A write while full is refused even when a read is accepted in the same cycle.
    // A read while empty is refused even when a write is accepted in the same cycle.
    // Because of this, the two RAM ports never touch the same address in one cycle.
    always_comb begin
        wr_accept = wr_req & ~full & ~clr;
        rd_accept = rd_req & ~empty & ~clr;
    end

    // RAM port drive: port 1 writes, port 2 only ever reads.
    always_comb begin
        ram_en1   = wr_accept;
        ram_we1   = wr_accept;
        ram_addr1 = wptr_q[AW-1:0];
        ram_DI1   = wr_data;
        ram_en2   = rd_accept;
        ram_we2   = 1'b0;
        ram_addr2 = rptr_q[AW-1:0];
    end

    // The RAM output register provides the one cycle of read latency, so data passes straight through.
    always_comb begin
        rd_data   = ram_DO2;
        rd_valid  = rd_valid_q;
        overflow  = overflow_q;
        underflow = underflow_q;
    end

    // Next-state logic: clr has priority and discards any read still in flight.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        rd_valid_d  = rd_accept;
        overflow_d  = wr_req & full & ~clr;
        underflow_d = rd_req & empty & ~clr;
        if (clr) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_accept) wptr_d = wptr_q + ONE;
            if (rd_accept) rptr_d = rptr_q + ONE;
        end
    end

    // State registers. Asynchronous reset drops an in-flight rd_valid at once.
    // NOTE: only the control state is reset; the RAM contents are left as they are.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Testbench for bram_fifo_ctrl.
// It includes a behavioural 64x16 dual-port RAM whose port 2 read data is registered.
// A table of per-cycle vectors comes first, followed by hand-written multi-cycle sequences.
module tb_bram_fifo_ctrl;

    localparam int AW = 6;
    localparam int DW = 16;

    logic          CLK;
    logic          RST_N;
    logic          clr;
    logic          wr_req;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          ram_en1;
    logic          ram_we1;
    logic [AW-1:0] ram_addr1;
    logic [DW-1:0] ram_DI1;
    logic          ram_en2;
    logic          ram_we2;
    logic [AW-1:0] ram_addr2;
    logic [DW-1:0] ram_DO2;

    bram_fifo_ctrl #(.AW(AW), .DW(DW), .AF_LEVEL(56), .AE_LEVEL(8)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .clr          (clr),
        .wr_req       (wr_req),
        .wr_data      (wr_data),
        .rd_req       (rd_req),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow),
        .ram_en1      (ram_en1),
        .ram_we1      (ram_we1),
        .ram_addr1    (ram_addr1),
        .ram_DI1      (ram_DI1),
        .ram_en2      (ram_en2),
        .ram_we2      (ram_we2),
        .ram_addr2    (ram_addr2),
        .ram_DO2      (ram_DO2)
    );

    // Behavioural block RAM: read-first, with registered port 2 output
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (ram_en1 && ram_we1) mem[ram_addr1] <= ram_DI1;
        if (ram_en2 && !ram_we2) ram_DO2 <= mem[ram_addr2];
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Apply inputs mid-cycle; comb RAM outputs may be checked right after
    task automatic drive(input logic wr, input logic rd, input logic cl, input logic [DW-1:0] d);
        @(negedge CLK);
        wr_req  = wr;
        rd_req  = rd;
        clr     = cl;
        wr_data = d;
        #1;
    endtask

    // Advance through the active edge and settle
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " count"},        32'(count), 32'd0);
        check({tag, " empty"},        32'(empty), 32'd1);
        check({tag, " full"},         32'(full), 32'd0);
        check({tag, " almost_empty"}, 32'(almost_empty), 32'd1);
        check({tag, " almost_full"},  32'(almost_full), 32'd0);
        check({tag, " rd_valid"},     32'(rd_valid), 32'd0);
        check({tag, " overflow"},     32'(overflow), 32'd0);
        check({tag, " underflow"},    32'(underflow), 32'd0);
    endtask

    typedef struct {
        logic          wr;
        logic          rd;
        logic          cl;
        logic [DW-1:0] data;
        logic          exp_en1;
        logic          exp_en2;
        logic [AW:0]   exp_count;
        logic          exp_empty;
        logic          exp_rv;
        logic [DW-1:0] exp_rdata;
        logic          exp_ovf;
        logic          exp_unf;
    } vec_t;

    vec_t vecs [12];
    logic [DW-1:0] sb [$];
    logic [DW-1:0] exp_word;

    initial begin
        // Watchdog so the run always ends on its own
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //               wr rd cl data      en1 en2 cnt   emp rv rdata     ovf unf
        vecs[0]  = '{1, 1, 0, 16'hA001, 1, 0, 7'd1, 0, 0, 16'h0000, 0, 1};
        vecs[1]  = '{0, 1, 0, 16'h0000, 0, 1, 7'd0, 1, 1, 16'hA001, 0, 0};
        vecs[2]  = '{1, 0, 0, 16'hA002, 1, 0, 7'd1, 0, 0, 16'h0000, 0, 0};
        vecs[3]  = '{1, 1, 0, 16'hA003, 1, 1, 7'd1, 0, 1, 16'hA002, 0, 0};
        vecs[4]  = '{1, 0, 0, 16'hA004, 1, 0, 7'd2, 0, 0, 16'h0000, 0, 0};
        vecs[5]  = '{0, 1, 0, 16'h0000, 0, 1, 7'd1, 0, 1, 16'hA003, 0, 0};
        vecs[6]  = '{0, 1, 0, 16'h0000, 0, 1, 7'd0, 1, 1, 16'hA004, 0, 0};
        vecs[7]  = '{0, 1, 0, 16'h0000, 0, 0, 7'd0, 1, 0, 16'h0000, 0, 1};
        vecs[8]  = '{0, 0, 0, 16'h0000, 0, 0, 7'd0, 1, 0, 16'h0000, 0, 0};
        vecs[9]  = '{1, 0, 1, 16'hA00F, 0, 0, 7'd0, 1, 0, 16'h0000, 0, 0};
        vecs[10] = '{1, 0, 0, 16'hA005, 1, 0, 7'd1, 0, 0, 16'h0000, 0, 0};
        vecs[11] = '{0, 1, 1, 16'h0000, 0, 0, 7'd0, 1, 0, 16'h0000, 0, 0};

        RST_N = 1'b0; clr = 1'b0; wr_req = 1'b0; rd_req = 1'b0; wr_data = '0;
        #1;
        check_reset_vals("reset");
        check("reset ram_we2", 32'(ram_we2), 32'd0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].cl, vecs[i].data);
            check($sformatf("vec%0d ram_en1", i), 32'(ram_en1), 32'(vecs[i].exp_en1));
            check($sformatf("vec%0d ram_en2", i), 32'(ram_en2), 32'(vecs[i].exp_en2));
            tick();
            check($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].exp_count));
            check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].exp_empty));
            check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].exp_rv));
            if (vecs[i].exp_rv)
                check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rdata));
            check($sformatf("vec%0d overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            check($sformatf("vec%0d underflow", i), 32'(underflow), 32'(vecs[i].exp_unf));
        end

        // Fill to full from reset, then overflow
        @(negedge CLK); RST_N = 1'b0; wr_req = 1'b0; rd_req = 1'b0; clr = 1'b0;
        @(negedge CLK); RST_N = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            drive(1'b1, 1'b0, 1'b0, 16'(i));
            check($sformatf("fill%0d ram_en1", i), 32'(ram_en1), 32'd1);
            check($sformatf("fill%0d ram_addr1", i), 32'(ram_addr1), 32'(i - 1));
            tick();
            check($sformatf("fill%0d count", i), 32'(count), 32'(i));
            check($sformatf("fill%0d almost_full", i), 32'(almost_full), 32'(i >= 56));
            check($sformatf("fill%0d almost_empty", i), 32'(almost_empty), 32'(i <= 8));
            check($sformatf("fill%0d full", i), 32'(full), 32'(i == 64));
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0041);
        check("ovf ram_en1", 32'(ram_en1), 32'd0);
        tick();
        check("ovf pulse", 32'(overflow), 32'd1);
        check("ovf count", 32'(count), 32'd64);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        check("ovf not sticky", 32'(overflow), 32'd0);

        // Drain 64 back-to-back reads, then underflow
        for (int i = 1; i <= 64; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0000);
            check($sformatf("drain%0d ram_en2", i), 32'(ram_en2), 32'd1);
            tick();
            check($sformatf("drain%0d rd_valid", i), 32'(rd_valid), 32'd1);
            check($sformatf("drain%0d rd_data", i), 32'(rd_data), 32'(i));
            check($sformatf("drain%0d count", i), 32'(count), 32'(64 - i));
        end
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        check("unf ram_en2", 32'(ram_en2), 32'd0);
        tick();
        check("unf pulse", 32'(underflow), 32'd1);
        check("unf rd_valid", 32'(rd_valid), 32'd0);
        check("unf empty", 32'(empty), 32'd1);
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        check("unf not sticky", 32'(underflow), 32'd0);

        // Streaming at count=10; pointers start at 64 and wrap past 127
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h1000 + 16'(i));
            sb.push_back(16'h1000 + 16'(i));
            tick();
        end
        check("stream prefill count", 32'(count), 32'd10);
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, 1'b1, 1'b0, 16'h2000 + 16'(i));
            sb.push_back(16'h2000 + 16'(i));
            tick();
            exp_word = sb.pop_front();
            check($sformatf("stream%0d count", i), 32'(count), 32'd10);
            check($sformatf("stream%0d rd_valid", i), 32'(rd_valid), 32'd1);
            check($sformatf("stream%0d rd_data", i), 32'(rd_data), 32'(exp_word));
        end

        // clr with count=20 and a read in flight
        drive(1'b0, 1'b0, 1'b1, 16'h0000);
        tick();
        check("clr0 count", 32'(count), 32'd0);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h3000 + 16'(i));
            tick();
        end
        drive(1'b1, 1'b1, 1'b0, 16'h3020);
        tick();
        check("clr pre count", 32'(count), 32'd20);
        check("clr pre rd_valid", 32'(rd_valid), 32'd1);
        drive(1'b1, 1'b1, 1'b1, 16'h3021);
        check("clr ram_en1", 32'(ram_en1), 32'd0);
        check("clr ram_en2", 32'(ram_en2), 32'd0);
        tick();
        check("clr count", 32'(count), 32'd0);
        check("clr empty", 32'(empty), 32'd1);
        check("clr rd_valid", 32'(rd_valid), 32'd0);
        check("clr underflow", 32'(underflow), 32'd0);

        // Asynchronous reset while rd_valid is high
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 16'h4000 + 16'(i));
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        check("arst pre rd_valid", 32'(rd_valid), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        check_reset_vals("arst");
        @(negedge CLK);
        RST_N = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'hBEEF);
        tick();
        check("post-arst count", 32'(count), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        tick();
        check("post-arst rd_valid", 32'(rd_valid), 32'd1);
        check("post-arst rd_data", 32'(rd_data), 32'hBEEF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Single-clock FIFO controller that uses an external 64x16 dual-port block RAM as its storage.
- Drives RAM port 1 as the write port and RAM port 2 as the read port.
- Consumes the registered read data from RAM port 2.
- Sits directly in front of the RAM. Both RAM clocks (CLK1, CLK2) are tied to CLK at the integration level.

Parameters:
- AW, 6, RAM address width; FIFO depth = 2**AW.
- DW, 16, data width.
- AF_LEVEL, 56, almost_full asserts when count >= AF_LEVEL.
- AE_LEVEL, 8, almost_empty asserts when count <= AE_LEVEL.

Ports:
- CLK  in  1  single clock; all logic on posedge.
- RST_N  in  1  asynchronous active-low reset.
- clr  in  1  synchronous flush.
- wr_req  in  1  write request.
- wr_data  in  DW  write data.
- rd_req  in  1  read request.
- rd_data  out  DW  read data, valid when rd_valid=1.
- rd_valid  out  1  read data strobe.
- full  out  1  FIFO full.
- empty  out  1  FIFO empty.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- count  out  AW+1  current occupancy, 0..2**AW.
- overflow  out  1  1-cycle pulse on a rejected write.
- underflow  out  1  1-cycle pulse on a rejected read.
- ram_en1  out  1  RAM port 1 enable.
- ram_we1  out  1  RAM port 1 write enable.
- ram_addr1  out  AW  RAM port 1 address.
- ram_DI1  out  DW  RAM port 1 write data.
- ram_en2  out  1  RAM port 2 enable.
- ram_we2  out  1  RAM port 2 write enable; constant 0.
- ram_addr2  out  AW  RAM port 2 address.
- ram_DO2  in  DW  RAM port 2 registered read data.

Behaviour:
- Reset: one clock CLK, asynchronous active-low reset RST_N.
  - Outputs while RST_N=0: wptr=rptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_valid=0, overflow=0, underflow=0.
  - RAM contents are not cleared.
- Pointers: wptr and rptr are AW+1 bits and wrap naturally at 2**AW*2.
  - count = wptr - rptr, computed modulo 2**(AW+1).
  - empty = (count==0); full = (count==2**AW).
  - All flags decode from registered pointers, so they are glitch-free in the cycle after the update.
- Write accept: wa = wr_req & ~full & ~clr.
  - Combinational RAM outputs: ram_en1 = ram_we1 = wa, ram_addr1 = wptr[AW-1:0], ram_DI1 = wr_data.
  - wptr increments at the clock edge when wa=1.
- Read accept: ra = rd_req & ~empty & ~clr.
  - Combinational RAM outputs: ram_en2 = ra, ram_addr2 = rptr[AW-1:0].
  - rptr increments at the clock edge when ra=1.
- Read latency is 1 cycle. rd_valid is registered ra. rd_data = ram_DO2, passed through combinationally, so data and rd_valid align.
  - Back-to-back reads on every cycle are supported at full throughput.
- Rejected write or read:
  - A write while full is rejected even if a read is accepted in the same cycle (no pass-through).
  - A read while empty is rejected even if a write is accepted in the same cycle (no bypass). The first data appears no earlier than 1 cycle after the write is accepted.
  - Consequence: ram_addr1 never equals ram_addr2 on a cycle where both enables are 1, so the RAM read-first collision never occurs.
- Simultaneous accepted read and write: count is unchanged; both pointers advance.
- overflow is registered (wr_req & full & ~clr). underflow is registered (rd_req & empty & ~clr). Each is a 1-cycle pulse per offending cycle and is not sticky.
- clr:
  - Sets wptr=rptr=0 at the next edge.
  - Forces ram_en1=ram_en2=0 in that cycle.
  - Clears rd_valid at the next edge; an in-flight read is discarded.
  - clr has priority over wr_req and rd_req.
- Reset mid-operation: an in-flight rd_valid is dropped immediately (asynchronously). Pointers return to 0.

Test Plan:
- Reset, then write 0x0001..0x0040 on 64 consecutive cycles -> full=1 after the 64th edge, count=64, almost_full rises when count reaches 56. A 65th write gives an overflow pulse and ram_en1=0.
- From full, read 64 consecutive cycles -> rd_valid held high from 1 cycle after the first read, rd_data sequence 0x0001..0x0040, then empty=1 and count=0. An extra read gives an underflow pulse and ram_en2=0.
- Streaming: simultaneous write and read every cycle with count=10 for 200 cycles -> count stays 10, data matches in order, pointers wrap past 127 with no corruption.
- Empty FIFO, wr_req and rd_req asserted in the same cycle -> write accepted, read rejected with an underflow pulse. A read the next cycle returns the written word with rd_valid 1 cycle later.
- Count=20 and a read in flight, assert clr together with wr_req and rd_req -> no RAM enables that cycle, next cycle count=0, empty=1, rd_valid=0.
- Drive RST_N low mid-stream while rd_valid=1 -> rd_valid, count and the flags go to their reset values without waiting for a clock edge. After release, a new write then read returns the new data.
